// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_ram_arbiter
// Brief   : Two-port (CPU/DMA) single-slot arbiter in front of a byte-write,
//           word-read RAM backend. Define SPI_RAM_ARB_ROUND_ROBIN_EN for
//           round-robin tie breaking; otherwise port 0 wins ties.
// Rev     : 1.0  initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [7:0]        p0_wdata,
  input  logic [7:0]        p1_wdata,
  output logic [31:0]       p0_rdata,
  output logic [31:0]       p1_rdata,
  output logic              p0_busy,
  output logic              p1_busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rbusy,
  input  logic              mem_wbusy
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_GAP   = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic              r_pend0, r_pend1;
  logic              r_op0, r_op1;
  logic [ADDR_W-1:0] r_addr0, r_addr1, r_mem_addr;
  logic [7:0]        r_wdata0, r_wdata1, r_mem_wdata;
  logic              r_gnt, r_gnt_wr;
  logic [31:0]       r_rdata0, r_rdata1;
  logic              w_win;
  logic              w_done;

  assign w_done = (r_state == c_DONE);

`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // On a tie the port that was not served last wins; reset favours port 0.
  assign w_win = r_pend1 & (~r_pend0 | ~r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last <= 1'b1;
    else if (w_done)
      r_last <= r_gnt;
  end
`else
  assign w_win = r_pend1 & ~r_pend0;
`endif

  // Pending slots: a strobe is captured only when the slot is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend0  <= 1'b0;
      r_op0    <= 1'b0;
      r_addr0  <= '0;
      r_wdata0 <= '0;
    end else if (w_done && !r_gnt) begin
      r_pend0 <= 1'b0;
    end else if ((p0_rd || p0_wr) && !r_pend0) begin
      r_pend0  <= 1'b1;
      r_op0    <= p0_wr;
      r_addr0  <= p0_addr;
      r_wdata0 <= p0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend1  <= 1'b0;
      r_op1    <= 1'b0;
      r_addr1  <= '0;
      r_wdata1 <= '0;
    end else if (w_done && r_gnt) begin
      r_pend1 <= 1'b0;
    end else if ((p1_rd || p1_wr) && !r_pend1) begin
      r_pend1  <= 1'b1;
      r_op1    <= p1_wr;
      r_addr1  <= p1_addr;
      r_wdata1 <= p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_gnt       <= 1'b0;
      r_gnt_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_pend0 || r_pend1) begin
            r_gnt       <= w_win;
            r_gnt_wr    <= w_win ? r_op1 : r_op0;
            r_mem_addr  <= w_win ? r_addr1 : r_addr0;
            r_mem_wdata <= w_win ? r_wdata1 : r_wdata0;
            r_state     <= c_ISSUE;
          end
        end
        c_ISSUE: r_state <= c_GAP;
        c_GAP:   r_state <= c_WAIT;
        c_WAIT: begin
          if (!(mem_rbusy || mem_wbusy))
            r_state <= c_DONE;
        end
        c_DONE: begin
          if (!r_gnt_wr) begin
            if (r_gnt)
              r_rdata1 <= mem_rdata;
            else
              r_rdata0 <= mem_rdata;
          end
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign mem_rd    = (r_state == c_ISSUE) && !r_gnt_wr;
  assign mem_wr    = (r_state == c_ISSUE) &&  r_gnt_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign p0_rdata  = r_rdata0;
  assign p1_rdata  = r_rdata1;
  assign p0_busy   = p0_rd | p0_wr | r_pend0;
  assign p1_busy   = p1_rd | p1_wr | r_pend1;

endmodule
`default_nettype wire

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning word-address width shared by both ports and the backend.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports p0_rd, p0_wr, p1_rd, p1_wr  in  1 each  single-cycle read/write strobes from requester 0 (CPU) and requester 1 (DMA).
REQ-005 SHALL have ports p0_addr, p1_addr  in  ADDR_W  word address; p0_wdata, p1_wdata  in  8  write byte.
REQ-006 SHALL have ports p0_rdata, p1_rdata  out  32  registered read data; p0_busy, p1_busy  out  1  request outstanding.
REQ-007 SHALL have ports mem_rd, mem_wr  out  1  backend strobes; mem_addr  out  ADDR_W; mem_wdata  out  8.
REQ-008 SHALL have ports mem_rdata  in  32; mem_rbusy, mem_wbusy  in  1  backend busy, valid from the cycle after a strobe.

Function
REQ-009 SHALL latch op, addr, and wdata per port into a pending slot on a strobe while that port's busy is low; strobes while busy is high SHALL be ignored.
REQ-010 SHALL treat p*_rd and p*_wr asserted together as a write.
REQ-011 SHALL drive pN_busy = pN_rd | pN_wr | pendN combinationally, so busy is high in the strobe cycle.
REQ-012 SHALL implement FSM states IDLE, ISSUE, GAP, WAIT, DONE.
REQ-013 IDLE: if any slot is pending, SHALL select a winner, register the grant, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-014 ISSUE: SHALL drive mem_rd or mem_wr high for exactly one cycle, with mem_addr/mem_wdata taken from the granted slot, then go to GAP.
REQ-015 GAP: SHALL wait one cycle unconditionally, then go to WAIT.
REQ-016 WAIT: SHALL remain in WAIT while (mem_rbusy | mem_wbusy) is high, and go to DONE otherwise.
REQ-017 DONE: for a read, SHALL load mem_rdata into the granted port's rdata; SHALL clear that pending slot, record the last grant, and go to IDLE.
REQ-018 SHALL keep mem_addr/mem_wdata stable from ISSUE through DONE, and SHALL hold mem_rd/mem_wr low outside ISSUE.
REQ-019 SHALL leave pN_rdata unchanged except in DONE of a read granted to port N; writes SHALL NOT alter rdata.
REQ-020 Latency, idle arbiter, backend busy for B cycles (B>=0):
- strobe in cycle 0; IDLE in cycle 1; ISSUE in cycle 2; GAP in cycle 3; WAIT spans cycles 4..4+B; DONE in cycle 5+B;
- busy low in cycle 6+B.
REQ-021 A port whose busy is low in cycle 6+B SHALL be able to strobe again in that same cycle.
REQ-022 Simultaneous pending on both ports: arbitration per REQ-028/REQ-029; the loser SHALL stay pending, with its latched data unchanged, until served.
REQ-023 A strobe on the non-granted port mid-transaction SHALL be latched and served next without disturbing the active transfer.

Reset
REQ-024 While rst is high: state IDLE, both pending slots clear, last-grant = port 1 (port 0 wins first tie).
REQ-025 While rst is high: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, p0_rdata=0, p1_rdata=0; busy outputs reflect only the strobe inputs.
REQ-026 Reset mid-transaction SHALL abort without any further backend strobe; the backend SHALL share the same rst.
REQ-027 After rst falls, SHALL accept strobes on the first rising edge.

Configuration
REQ-028 With macro SPI_RAM_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the port not granted last.
REQ-029 Without SPI_RAM_ARB_ROUND_ROBIN_EN, ties SHALL always go to port 0; last-grant state may be omitted.

Verification
REQ-030 Single read: p0_rd addr 0x0010, backend B=3, mem_rdata 0xDEADBEEF -> mem_rd in cycle 2 with mem_addr 0x0010; p0_rdata=0xDEADBEEF and p0_busy low in cycle 9.
REQ-031 Single write: p1_wr addr 0x1234, wdata 0xA5 -> one mem_wr pulse with mem_addr 0x1234, mem_wdata 0xA5; p1_rdata unchanged.
REQ-032 Tie: p0_rd and p1_rd in the same cycle, twice back-to-back ->
- with SPI_RAM_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1;
- without SPI_RAM_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1 only because port 0 is already served; a p0 re-strobe before p1 is served -> 0,0.
REQ-033 Ignored strobe: p0_rd addr 0x0001, then p0_wr addr 0x0002 while p0_busy is high -> exactly one backend access, to 0x0001.
REQ-034 Reset in WAIT with both ports pending -> no further mem_rd/mem_wr, both busy low after release, next strobe served normally.
REQ-035 Both p0_rd and p0_wr in one cycle, wdata 0x3C -> mem_wr pulse only, mem_wdata 0x3C.
